ov5642_pixel_aligner: RTL and testbench
=======================================

Name: ov5642_pixel_aligner

Overview:
Parametrised successor to the fixed 2-byte camera byte aligner. Packs an 8-bit camera byte stream into pixels of BYTES_PER_PIXEL bytes with selectable byte order, and presents them on an AXI-Stream master that supports backpressure. It synchronises to the first end-of-line, flushes partial pixels at line end, and reports line length, misalignment and overflow statistics. It sits between the parallel-video capture front end and the frame-buffer DMA / colour converter.

Parameters:
BYTES_PER_PIXEL, 2, bytes packed per output beat; legal values 1..4.
MSB_FIRST, 1, 1 = first received byte lands in the top byte of tdata_out; 0 = first byte lands in the bottom byte.
CNT_W, 12, width of the per-line pixel counter; saturates at 2^CNT_W-1.
STAT_W, 16, width of the statistics counters; saturating.

Ports:
pclk  in  1  pixel clock; the only clock.
rst_n  in  1  asynchronous, active-low reset.
enable  in  1  low forces the SYNC state and clears partial pixel data.
tdata_in  in  8  camera byte.
tvalid_in  in  1  byte valid. There is no tready: the source cannot stall.
tlast_in  in  1  end of line, qualified by tvalid_in.
tdata_out  out  8*BYTES_PER_PIXEL  packed pixel.
tvalid_out  out  1  output beat valid.
tlast_out  out  1  last pixel of the line.
tready_out  in  1  downstream ready.
synced  out  1  high while in the ACTIVE state.
line_pixels  out  CNT_W  pixel count of the last completed line, including a padded flush beat.
misalign_cnt  out  STAT_W  number of lines that ended on a partial pixel.
overflow_cnt  out  STAT_W  number of pixels dropped because of backpressure.

Behaviour:
- Reset values: tvalid_out=0, tlast_out=0, tdata_out=0, synced=0, line_pixels=0, misalign_cnt=0, overflow_cnt=0. Internal state is SYNC, byte index=0, line counter=0.
- State SYNC: input bytes are ignored. A beat with tvalid_in&tlast_in&enable moves the block to ACTIVE on the next cycle. That beat itself is discarded.
- State ACTIVE: each tvalid_in byte is written to slot idx of the assembly register, and idx increments.
  - Slot mapping: with MSB_FIRST=1, slot k lands in byte (BPP-1-k) of the output; with MSB_FIRST=0, slot k lands in byte k.
- Pixel completion: when idx==BPP-1 and tvalid_in is high, the pixel is complete. The completed pixel is loaded into the output register in the same edge and idx wraps to 0.
  - Latency: tvalid_out rises 1 cycle after the final byte is sampled.
- Line end on a partial pixel: tlast_in arrives with idx != BPP-1.
  - The partial pixel is flushed with unfilled slots zeroed and tlast_out=1.
  - misalign_cnt increments.
  - idx resets to 0.
- Line end on a complete pixel: tlast_in on the completing byte sets tlast_out=1 on that beat.
- Line statistics: at every tlast beat, line_pixels is loaded with line counter+1 and the line counter clears.
- Output handshake:
  - The output register holds its value while tvalid_out&!tready_out.
  - The register is cleared on tvalid_out&tready_out unless a new pixel loads on the same edge; in that case the new pixel replaces the old one.
- Overflow: a pixel completes while tvalid_out&!tready_out.
  - The new pixel is dropped and overflow_cnt increments.
  - If the dropped pixel carried tlast, the held beat gets tlast_out forced to 1, so line framing is preserved.
- enable falling: the block returns to SYNC and idx=0. Any beat already in the output register still completes its handshake.
- BPP=1: every byte is a pixel. The misalignment path is never taken.
- All counters saturate; they do not wrap.
- Asserting rst_n low mid-line aborts immediately to the reset values. The output beat is lost.

Decomposition:
- Shared package ov5642_pkg holds:
  - the state enum (SYNC, ACTIVE);
  - BPP_MAX=4;
  - the function bytes_to_bits(n)=8*n.
- One sub-module, ov5642_axis_out_reg. It is the single-entry output register with tready handling and the overflow/tlast-merge logic, and is reusable by the colour converter.
- Byte assembly, sync FSM and statistics stay in the top module.

Test Plan:
- BPP=2, MSB_FIRST=1: send a tlast to sync, then bytes A1 B2 C3 D4 with tlast on D4, tready=1 → beats 0xA1B2 and 0xC3D4 (tlast=1); line_pixels=2; misalign_cnt=0.
- BPP=3, MSB_FIRST=0: after sync, send 11 22 33 44 with tlast on 44 → beats 0x332211 and 0x000044 (tlast=1); misalign_cnt=1; line_pixels=2.
- Before sync: send bytes 55 66 77 without tlast → no tvalid_out and synced=0. The first tlast beat sets synced=1 one cycle later and produces no output.
- Backpressure, BPP=2: hold tready=0 across 3 completed pixels → first beat held stable; overflow_cnt=2. When the dropped last pixel carried tlast, the held beat shows tlast_out=1.
- Mid-stream: drop enable after 1 of 2 bytes → synced=0, no output; the next pixel only appears after a new sync tlast. Pulse rst_n low mid-line → all outputs return to 0 asynchronously.
- BPP=1, MSB_FIRST=1: 5 bytes with tlast on the fifth → 5 beats equal to the input bytes; line_pixels=5; misalign_cnt=0.

Source files
------------

// File: rtl/ov5642_pkg.sv
// ----------------------------------------------------------------------------
// ov5642_pkg
// Shared definitions for the OV5642 pixel aligner and its output register.
//   align_state_e  : SYNC (waiting for the first end-of-line) / ACTIVE.
//   BPP_MAX        : largest supported bytes-per-pixel.
//   IDX_W          : width of the byte-slot index (covers 0..BPP_MAX-1).
//   bytes_to_bits  : pixel width in bits for a given byte count.
// ----------------------------------------------------------------------------
package ov5642_pkg;

  typedef enum logic {
    SYNC   = 1'b0,
    ACTIVE = 1'b1
  } align_state_e;

  localparam int BPP_MAX = 4;
  localparam int IDX_W   = 2;

  function automatic int bytes_to_bits(input int n);
    return 8 * n;
  endfunction

endpackage

// File: rtl/ov5642_axis_out_reg.sv
// ----------------------------------------------------------------------------
// ov5642_axis_out_reg
// Single-entry AXI-Stream output register with backpressure handling.
// A new beat is accepted when the register is empty or being drained on the
// same edge. While a beat is stalled (tvalid & !tready) a new beat is dropped
// and reported on 'drop'; if the dropped beat carried tlast, the held beat
// inherits tlast so downstream line framing is preserved.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   load_valid          a new beat is offered this cycle
//   load_data[W-1:0]    data of the offered beat
//   load_last           tlast of the offered beat
//   tready              downstream ready
//   tdata/tvalid/tlast  registered AXI-Stream master outputs
//   drop                combinational: the offered beat is discarded this cycle
// ----------------------------------------------------------------------------
module ov5642_axis_out_reg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_valid,
  input  logic [W-1:0] load_data,
  input  logic         load_last,
  input  logic         tready,
  output logic [W-1:0] tdata,
  output logic         tvalid,
  output logic         tlast,
  output logic         drop
);

  logic stall;

  assign stall = tvalid && !tready;
  assign drop  = stall && load_valid;

  // NOTE: state registers are written with non-blocking assignments so every
  // always_ff sees the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tdata  <= '0;
      tvalid <= 1'b0;
      tlast  <= 1'b0;
    end else if (stall) begin
      // Held beat stays put; a dropped end-of-line still marks the line end.
      if (load_valid && load_last) begin
        tlast <= 1'b1;
      end
    end else if (load_valid) begin
      tdata  <= load_data;
      tvalid <= 1'b1;
      tlast  <= load_last;
    end else if (tvalid) begin
      // Handshake completed with nothing new behind it: empty the register.
      tdata  <= '0;
      tvalid <= 1'b0;
      tlast  <= 1'b0;
    end
  end

endmodule

// File: rtl/ov5642_pixel_aligner.sv
// ----------------------------------------------------------------------------
// ov5642_pixel_aligner
// Packs an 8-bit camera byte stream into BYTES_PER_PIXEL-byte pixels and
// presents them on an AXI-Stream master with backpressure. The block stays
// in SYNC until the first end-of-line beat, then assembles pixels in ACTIVE.
// A line that ends mid-pixel is flushed with the unfilled bytes zeroed.
//
// Parameters:
//   BYTES_PER_PIXEL  1..4 bytes per output beat
//   MSB_FIRST        1: first byte in the top byte of tdata_out; 0: bottom
//   CNT_W            width of the per-line pixel counter (saturating)
//   STAT_W           width of the statistics counters (saturating)
//
// Ports:
//   pclk, rst_n                  clock, asynchronous active-low reset
//   enable                       low: back to SYNC, partial pixel discarded
//   tdata_in/tvalid_in/tlast_in  camera byte stream (cannot be stalled)
//   tdata_out/tvalid_out/tlast_out, tready_out   AXI-Stream pixel output
//   synced                       high while ACTIVE
//   line_pixels                  pixels in the last completed line
//   misalign_cnt                 lines that ended on a partial pixel
//   overflow_cnt                 pixels dropped due to backpressure
// ----------------------------------------------------------------------------
module ov5642_pixel_aligner
  import ov5642_pkg::*;
#(
  parameter int BYTES_PER_PIXEL = 2,
  parameter bit MSB_FIRST       = 1'b1,
  parameter int CNT_W           = 12,
  parameter int STAT_W          = 16
) (
  input  logic                                       pclk,
  input  logic                                       rst_n,
  input  logic                                       enable,
  input  logic [7:0]                                 tdata_in,
  input  logic                                       tvalid_in,
  input  logic                                       tlast_in,
  output logic [bytes_to_bits(BYTES_PER_PIXEL)-1:0]  tdata_out,
  output logic                                       tvalid_out,
  output logic                                       tlast_out,
  input  logic                                       tready_out,
  output logic                                       synced,
  output logic [CNT_W-1:0]                           line_pixels,
  output logic [STAT_W-1:0]                          misalign_cnt,
  output logic [STAT_W-1:0]                          overflow_cnt
);

  localparam int               PIX_W    = bytes_to_bits(BYTES_PER_PIXEL);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_PIXEL - 1);

  align_state_e     state_q;
  logic [IDX_W-1:0] idx_q;
  logic [7:0]       asm_q [BPP_MAX];
  logic [CNT_W-1:0] line_cnt_q;

  logic             in_beat;
  logic             at_last_slot;
  logic             pix_done;
  logic [7:0]       slot_byte [BPP_MAX];
  logic [PIX_W-1:0] pix_data;
  logic [CNT_W-1:0] line_cnt_inc;
  logic             ovf_drop;

  assign synced       = (state_q == ACTIVE);
  assign in_beat      = enable && tvalid_in && (state_q == ACTIVE);
  assign at_last_slot = (idx_q == LAST_IDX);
  // A pixel leaves either when its last slot fills or when the line ends.
  assign pix_done     = in_beat && (at_last_slot || tlast_in);
  assign line_cnt_inc = (line_cnt_q == '1) ? line_cnt_q : line_cnt_q + CNT_W'(1);

  // Slot view of the pixel being completed: earlier slots come from the
  // assembly register, the current slot from the input byte, later slots
  // (only present on a line-end flush) read as zero.
  // NOTE: every output of an always_comb gets a value on every path so no
  // latch is inferred.
  always_comb begin
    for (int k = 0; k < BPP_MAX; k++) begin
      if (k >= BYTES_PER_PIXEL) begin
        slot_byte[k] = 8'h00;
      end else if (IDX_W'(k) == idx_q) begin
        slot_byte[k] = tdata_in;
      end else if (IDX_W'(k) < idx_q) begin
        slot_byte[k] = asm_q[k];
      end else begin
        slot_byte[k] = 8'h00;
      end
    end
  end

  always_comb begin
    pix_data = '0;
    for (int k = 0; k < BYTES_PER_PIXEL; k++) begin
      if (MSB_FIRST) begin
        pix_data[8*(BYTES_PER_PIXEL-1-k) +: 8] = slot_byte[k];
      end else begin
        pix_data[8*k +: 8] = slot_byte[k];
      end
    end
  end

  // Sync FSM and byte assembly.
  // NOTE: the assembly register is only BPP_MAX bytes, so it is reset along
  // with the rest of the state rather than left undefined like a RAM.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SYNC;
      idx_q   <= '0;
      for (int k = 0; k < BPP_MAX; k++) begin
        asm_q[k] <= 8'h00;
      end
    end else if (!enable) begin
      state_q <= SYNC;
      idx_q   <= '0;
      for (int k = 0; k < BPP_MAX; k++) begin
        asm_q[k] <= 8'h00;
      end
    end else if (state_q == SYNC) begin
      // The end-of-line beat that synchronises us is itself discarded.
      if (tvalid_in && tlast_in) begin
        state_q <= ACTIVE;
      end
    end else if (tvalid_in) begin
      if (pix_done) begin
        idx_q <= '0;
      end else begin
        asm_q[idx_q] <= tdata_in;
        idx_q        <= idx_q + IDX_W'(1);
      end
    end
  end

  // Line statistics. The line counter holds pixels completed so far in the
  // current line, so the tlast pixel itself is the "+1".
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      line_cnt_q   <= '0;
      line_pixels  <= '0;
      misalign_cnt <= '0;
    end else if (!enable) begin
      line_cnt_q <= '0;
    end else if (pix_done) begin
      if (tlast_in) begin
        line_pixels <= line_cnt_inc;
        line_cnt_q  <= '0;
        if (!at_last_slot && misalign_cnt != '1) begin
          misalign_cnt <= misalign_cnt + STAT_W'(1);
        end
      end else begin
        line_cnt_q <= line_cnt_inc;
      end
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_cnt <= '0;
    end else if (ovf_drop && overflow_cnt != '1) begin
      overflow_cnt <= overflow_cnt + STAT_W'(1);
    end
  end

  ov5642_axis_out_reg #(
    .W (PIX_W)
  ) u_out_reg (
    .clk        (pclk),
    .rst_n      (rst_n),
    .load_valid (pix_done),
    .load_data  (pix_data),
    .load_last  (tlast_in),
    .tready     (tready_out),
    .tdata      (tdata_out),
    .tvalid     (tvalid_out),
    .tlast      (tlast_out),
    .drop       (ovf_drop)
  );

endmodule

// File: tb/tb_ov5642_pixel_aligner.sv
// ----------------------------------------------------------------------------
// tb_ov5642_pixel_aligner
// Four aligner configurations share one input stream:
//   d0: BPP=2 MSB_FIRST=1   d1: BPP=3 MSB_FIRST=0 (3-bit counters, saturate)
//   d2: BPP=1 MSB_FIRST=1   d3: BPP=4 MSB_FIRST=0
// A byte/pixel-level reference model predicts every output each cycle;
// directed sequences add fixed expected values for the key scenarios.
// ----------------------------------------------------------------------------
module tb_ov5642_pixel_aligner;

  logic       pclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] tdata_in = 8'h00;
  logic       tvalid_in = 1'b0;
  logic       tlast_in = 1'b0;
  logic       tready_out = 1'b0;

  always #5 pclk = ~pclk;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] td0;
  logic [23:0] td1;
  logic [7:0]  td2;
  logic [31:0] td3;
  logic [3:0]  tv, tl, sy;
  logic [11:0] lp0, lp2, lp3;
  logic [2:0]  lp1, mc1, oc1;
  logic [15:0] mc0, mc2, mc3, oc0, oc2, oc3;

  ov5642_pixel_aligner #(.BYTES_PER_PIXEL(2), .MSB_FIRST(1'b1), .CNT_W(12), .STAT_W(16)) u_d0 (
    .pclk(pclk), .rst_n(rst_n), .enable(enable), .tdata_in(tdata_in), .tvalid_in(tvalid_in),
    .tlast_in(tlast_in), .tdata_out(td0), .tvalid_out(tv[0]), .tlast_out(tl[0]),
    .tready_out(tready_out), .synced(sy[0]), .line_pixels(lp0), .misalign_cnt(mc0),
    .overflow_cnt(oc0));

  ov5642_pixel_aligner #(.BYTES_PER_PIXEL(3), .MSB_FIRST(1'b0), .CNT_W(3), .STAT_W(3)) u_d1 (
    .pclk(pclk), .rst_n(rst_n), .enable(enable), .tdata_in(tdata_in), .tvalid_in(tvalid_in),
    .tlast_in(tlast_in), .tdata_out(td1), .tvalid_out(tv[1]), .tlast_out(tl[1]),
    .tready_out(tready_out), .synced(sy[1]), .line_pixels(lp1), .misalign_cnt(mc1),
    .overflow_cnt(oc1));

  ov5642_pixel_aligner #(.BYTES_PER_PIXEL(1), .MSB_FIRST(1'b1), .CNT_W(12), .STAT_W(16)) u_d2 (
    .pclk(pclk), .rst_n(rst_n), .enable(enable), .tdata_in(tdata_in), .tvalid_in(tvalid_in),
    .tlast_in(tlast_in), .tdata_out(td2), .tvalid_out(tv[2]), .tlast_out(tl[2]),
    .tready_out(tready_out), .synced(sy[2]), .line_pixels(lp2), .misalign_cnt(mc2),
    .overflow_cnt(oc2));

  ov5642_pixel_aligner #(.BYTES_PER_PIXEL(4), .MSB_FIRST(1'b0), .CNT_W(12), .STAT_W(16)) u_d3 (
    .pclk(pclk), .rst_n(rst_n), .enable(enable), .tdata_in(tdata_in), .tvalid_in(tvalid_in),
    .tlast_in(tlast_in), .tdata_out(td3), .tvalid_out(tv[3]), .tlast_out(tl[3]),
    .tready_out(tready_out), .synced(sy[3]), .line_pixels(lp3), .misalign_cnt(mc3),
    .overflow_cnt(oc3));

  // ---------------- reference model ----------------
  function automatic int bpp_of(input int d);
    case (d)
      0: return 2;
      1: return 3;
      2: return 1;
      default: return 4;
    endcase
  endfunction

  function automatic bit msb_of(input int d);
    return (d == 0 || d == 2);
  endfunction

  function automatic int cnt_max(input int d);
    return (d == 1) ? 7 : 4095;
  endfunction

  function automatic int stat_max(input int d);
    return (d == 1) ? 7 : 65535;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // acc holds received bytes in arrival order (byte k at bits 8k+:8).
  function automatic logic [31:0] pack(input int d, input logic [31:0] acc, input int n);
    logic [31:0] r;
    int          pos;
    r = 32'h0;
    for (int k = 0; k < n; k++) begin
      pos = msb_of(d) ? (bpp_of(d) - 1 - k) : k;
      r = r | (((acc >> (8 * k)) & 32'hFF) << (8 * pos));
    end
    return r;
  endfunction

  bit          m_sync [4];
  int          m_cnt  [4];
  logic [31:0] m_acc  [4];
  int          m_lc   [4];
  int          m_lp   [4];
  int          m_mis  [4];
  int          m_ovf  [4];
  bit          m_v    [4];
  logic [31:0] m_d    [4];
  bit          m_l    [4];

  task automatic model_reset();
    for (int d = 0; d < 4; d++) begin
      m_sync[d] = 1'b0; m_cnt[d] = 0; m_acc[d] = 32'h0; m_lc[d] = 0; m_lp[d] = 0;
      m_mis[d] = 0; m_ovf[d] = 0; m_v[d] = 1'b0; m_d[d] = 32'h0; m_l[d] = 1'b0;
    end
  endtask

  // One clock edge of every configuration, from the inputs held before it.
  task automatic model_step();
    bit          done;
    bit          plast;
    bit          hold;
    logic [31:0] pix;
    for (int d = 0; d < 4; d++) begin
      done = 1'b0; plast = 1'b0; pix = 32'h0;
      hold = m_v[d] && !tready_out;
      if (!enable) begin
        m_sync[d] = 1'b0; m_cnt[d] = 0; m_acc[d] = 32'h0; m_lc[d] = 0;
      end else if (!m_sync[d]) begin
        if (tvalid_in && tlast_in) m_sync[d] = 1'b1;
      end else if (tvalid_in) begin
        m_acc[d] = m_acc[d] | (32'(tdata_in) << (8 * m_cnt[d]));
        m_cnt[d]++;
        if (m_cnt[d] == bpp_of(d) || tlast_in) begin
          done  = 1'b1;
          plast = tlast_in;
          pix   = pack(d, m_acc[d], m_cnt[d]);
          if (tlast_in) begin
            m_lp[d] = sat(m_lc[d] + 1, cnt_max(d));
            m_lc[d] = 0;
            if (m_cnt[d] != bpp_of(d)) m_mis[d] = sat(m_mis[d] + 1, stat_max(d));
          end else begin
            m_lc[d] = sat(m_lc[d] + 1, cnt_max(d));
          end
          m_cnt[d] = 0;
          m_acc[d] = 32'h0;
        end
      end
      if (hold) begin
        if (done) begin
          m_ovf[d] = sat(m_ovf[d] + 1, stat_max(d));
          if (plast) m_l[d] = 1'b1;
        end
      end else if (done) begin
        m_v[d] = 1'b1; m_d[d] = pix; m_l[d] = plast;
      end else if (m_v[d]) begin
        m_v[d] = 1'b0; m_d[d] = 32'h0; m_l[d] = 1'b0;
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [31:0] gd [4];
    logic [31:0] glp [4];
    logic [31:0] gmc [4];
    logic [31:0] goc [4];
    gd[0] = 32'(td0); gd[1] = 32'(td1); gd[2] = 32'(td2); gd[3] = td3;
    glp[0] = 32'(lp0); glp[1] = 32'(lp1); glp[2] = 32'(lp2); glp[3] = 32'(lp3);
    gmc[0] = 32'(mc0); gmc[1] = 32'(mc1); gmc[2] = 32'(mc2); gmc[3] = 32'(mc3);
    goc[0] = 32'(oc0); goc[1] = 32'(oc1); goc[2] = 32'(oc2); goc[3] = 32'(oc3);
    for (int d = 0; d < 4; d++) begin
      check($sformatf("d%0d_tvalid", d), 32'(tv[d]), 32'(m_v[d]));
      check($sformatf("d%0d_tdata", d), gd[d], m_d[d]);
      check($sformatf("d%0d_tlast", d), 32'(tl[d]), 32'(m_l[d]));
      check($sformatf("d%0d_synced", d), 32'(sy[d]), 32'(m_sync[d]));
      check($sformatf("d%0d_line_pixels", d), glp[d], 32'(m_lp[d]));
      check($sformatf("d%0d_misalign", d), gmc[d], 32'(m_mis[d]));
      check($sformatf("d%0d_overflow", d), goc[d], 32'(m_ovf[d]));
    end
  endtask

  // Drive inputs away from the edge, advance one edge, then compare.
  task automatic cycle(input bit en, input bit v, input bit l, input logic [7:0] b, input bit rdy);
    enable = en; tvalid_in = v; tlast_in = l; tdata_in = b; tready_out = rdy;
    @(posedge pclk);
    model_step();
    #1;
    compare_all();
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset();
    #2;
    rst_n = 1'b0; tvalid_in = 1'b0; tlast_in = 1'b0;
    #1;
    check("rst_tvalid", 32'(tv), 32'h0);
    check("rst_tlast", 32'(tl), 32'h0);
    check("rst_synced", 32'(sy), 32'h0);
    check("rst_tdata", 32'(td0) | 32'(td1) | 32'(td2) | td3, 32'h0);
    check("rst_stats", 32'(lp0) | 32'(lp1) | 32'(lp2) | 32'(lp3) | 32'(mc0) | 32'(mc1) |
          32'(mc2) | 32'(mc3) | 32'(oc0) | 32'(oc1) | 32'(oc2) | 32'(oc3), 32'h0);
    model_reset();
    @(negedge pclk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] b;
    bit         rdy;
    bit         v;

    model_reset();
    do_reset();

    // Bytes before the first end-of-line are ignored.
    cycle(1, 1, 0, 8'h55, 1);
    cycle(1, 1, 0, 8'h66, 1);
    cycle(1, 1, 0, 8'h77, 1);
    check("presync_synced", 32'(sy), 32'h0);
    check("presync_tvalid", 32'(tv), 32'h0);
    cycle(1, 1, 1, 8'h88, 1);
    check("sync_rise", 32'(sy), 32'hF);
    check("sync_no_output", 32'(tv), 32'h0);

    // Line A1 B2 C3 D4.
    cycle(1, 1, 0, 8'hA1, 1);
    cycle(1, 1, 0, 8'hB2, 1);
    check("d0_beat0", 32'(td0), 32'hA1B2);
    check("d0_beat0_last", 32'(tl[0]), 32'h0);
    cycle(1, 1, 0, 8'hC3, 1);
    check("d1_full_pixel", 32'(td1), 32'hC3B2A1);
    cycle(1, 1, 1, 8'hD4, 1);
    check("d0_beat1", 32'(td0), 32'hC3D4);
    check("d0_beat1_last", 32'(tl[0]), 32'h1);
    check("d1_flush", 32'(td1), 32'h0000D4);
    check("d3_lsb_first", td3, 32'hD4C3B2A1);
    check("d0_line_pixels", 32'(lp0), 32'd2);
    check("d0_misalign", 32'(mc0), 32'd0);
    check("d1_misalign", 32'(mc1), 32'd1);

    // Line 11 22 33 44 on the 3-byte, LSB-first configuration.
    cycle(1, 1, 0, 8'h11, 1);
    cycle(1, 1, 0, 8'h22, 1);
    cycle(1, 1, 0, 8'h33, 1);
    check("d1_pixel_332211", 32'(td1), 32'h332211);
    cycle(1, 1, 1, 8'h44, 1);
    check("d1_flush_44", 32'(td1), 32'h000044);
    check("d1_flush_last", 32'(tl[1]), 32'h1);
    check("d1_line_pixels", 32'(lp1), 32'd2);

    // One byte per pixel: five-byte line.
    for (int i = 1; i <= 5; i++) begin
      cycle(1, 1, (i == 5), 8'(8'h30 + i), 1);
      check("d2_byte_pixel", 32'(td2), 32'(8'h30 + i));
    end
    check("d2_line_pixels", 32'(lp2), 32'd5);
    check("d2_misalign", 32'(mc2), 32'd0);

    // Backpressure: three pixels completed while stalled.
    do_reset();
    cycle(1, 1, 1, 8'h00, 1);
    for (int i = 1; i <= 6; i++) cycle(1, 1, (i == 6), 8'(i), 0);
    check("bp_held_data", 32'(td0), 32'h0102);
    check("bp_held_valid", 32'(tv[0]), 32'h1);
    check("bp_merged_last", 32'(tl[0]), 32'h1);
    check("bp_overflow", 32'(oc0), 32'd2);
    cycle(1, 0, 0, 8'h00, 1);
    check("bp_drained", 32'(tv[0]), 32'h0);

    // enable drops mid-pixel: no output until a new sync.
    do_reset();
    cycle(1, 1, 1, 8'h00, 1);
    cycle(1, 1, 0, 8'hAA, 1);
    cycle(0, 1, 0, 8'hBB, 1);
    check("en_low_synced", 32'(sy[0]), 32'h0);
    check("en_low_no_beat", 32'(tv[0]), 32'h0);
    cycle(1, 1, 0, 8'hCC, 1);
    cycle(1, 1, 0, 8'hDD, 1);
    check("en_resync_wait", 32'(tv[0]), 32'h0);
    cycle(1, 1, 1, 8'hEE, 1);
    cycle(1, 1, 0, 8'h12, 1);
    cycle(1, 1, 0, 8'h34, 1);
    check("en_resync_pixel", 32'(td0), 32'h1234);
    cycle(1, 1, 1, 8'h56, 1);

    // Long line: the 3-bit line counter of d1 saturates.
    for (int i = 1; i <= 30; i++) cycle(1, 1, (i == 30), 8'(i), 1);
    check("long_d0", 32'(lp0), 32'd15);
    check("long_d1_sat", 32'(lp1), 32'd7);
    check("long_d2", 32'(lp2), 32'd30);
    check("long_d3", 32'(lp3), 32'd8);

    // Randomized traffic, light then heavy backpressure.
    for (int i = 0; i < 4000; i++) begin
      rdy = (i < 2000) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0);
      v   = ($urandom_range(0, 3) != 0);
      b   = 8'($urandom);
      cycle(($urandom_range(0, 99) != 0), v, v && ($urandom_range(0, 5) == 0), b, rdy);
    end

    // Mid-line asynchronous reset, then more traffic.
    cycle(1, 1, 0, 8'h5A, 0);
    do_reset();
    for (int i = 0; i < 800; i++) begin
      v = ($urandom_range(0, 3) != 0);
      b = 8'($urandom);
      cycle(1, v, v && ($urandom_range(0, 7) == 0), b, ($urandom_range(0, 2) != 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
